// File: rtl/csh_data_seq_if.sv
// Bus bundle between the cache control logic, the memory refill path and the
// cache data RAMs, as seen by the csh_data_seq sequencer (slave) and its users (master).
interface csh_data_seq_if #(
    parameter int WAYS  = 4,
    parameter int ADR_W = 9
);
    logic                     cpu_req_h;
    logic                     cpu_wr_h;
    logic [$clog2(WAYS)-1:0]  cpu_way;
    logic [ADR_W-1:0]         cpu_adr;
    logic [35:0]              cpu_wdata;
    logic                     cpu_gnt_h;
    logic [35:0]              cpu_rdata;
    logic                     cpu_rdata_vld_h;
    logic                     par_err_h;

    logic                     fill_req_h;
    logic [$clog2(WAYS)-1:0]  fill_way;
    logic [ADR_W-1:0]         fill_adr;
    logic                     mem_data_vld_h;
    logic                     mem_rdy_h;
    logic [35:0]              mem_data;
    logic                     fill_busy_h;
    logic                     fill_done_h;

    logic [ADR_W-1:0]         cache_adr_h;
    logic [WAYS-1:0]          csh_sel_l;
    logic                     csh_en_csh_data_l;
    logic [WAYS-1:0]          cache_wr_l;
    logic [35:0]              mem_to_cache_h;
    logic                     csh_par_bit_in_h;
    logic [35:0]              cache_data_h;
    logic                     csh_par_bit_h;

    modport slave (
        input  cpu_req_h, cpu_wr_h, cpu_way, cpu_adr, cpu_wdata,
        output cpu_gnt_h, cpu_rdata, cpu_rdata_vld_h, par_err_h,
        input  fill_req_h, fill_way, fill_adr, mem_data_vld_h, mem_data,
        output mem_rdy_h, fill_busy_h, fill_done_h,
        output cache_adr_h, csh_sel_l, csh_en_csh_data_l, cache_wr_l,
        output mem_to_cache_h, csh_par_bit_in_h,
        input  cache_data_h, csh_par_bit_h
    );

    modport master (
        output cpu_req_h, cpu_wr_h, cpu_way, cpu_adr, cpu_wdata,
        input  cpu_gnt_h, cpu_rdata, cpu_rdata_vld_h, par_err_h,
        output fill_req_h, fill_way, fill_adr, mem_data_vld_h, mem_data,
        input  mem_rdy_h, fill_busy_h, fill_done_h,
        input  cache_adr_h, csh_sel_l, csh_en_csh_data_l, cache_wr_l,
        input  mem_to_cache_h, csh_par_bit_in_h,
        output cache_data_h, csh_par_bit_h
    );
endinterface

// File: rtl/csh_data_seq.sv
// Sequencer/arbiter for one cache data slice: shares the RAM address, select,
// output-enable and write-strobe lines between CPU accesses and line refills.
module csh_data_seq #(
    parameter int WAYS     = 4,
    parameter int WPL      = 4,
    parameter int IDX_W    = 7,
    parameter int WR_PULSE = 2
) (
    input  logic          clk,
    input  logic          reset,
    csh_data_seq_if.slave bus
);
    localparam int OFS_W = $clog2(WPL);
    localparam int ADR_W = IDX_W + OFS_W;
    localparam int CNT_W = OFS_W + 1;
    localparam int WAY_W = $clog2(WAYS);
    localparam int STB_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [STB_W-1:0] STB_LAST   = STB_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] FILL_WORDS = CNT_W'(WPL);

    typedef enum logic [2:0] {
        IDLE, RD_ADR, RD_CAP, WR_SET, WR_STB, WR_HLD, FILL_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [WAY_W-1:0]   op_way_q, op_way_d;
    logic [ADR_W-1:0]   op_adr_q;
    logic [35:0]        op_wdata_q;
    logic               op_par_q;
    logic               op_fill_q;
    logic [WAY_W-1:0]   fill_way_q;
    logic [ADR_W-1:0]   fill_adr_q;
    logic [CNT_W-1:0]   fill_cnt_q;
    logic               fill_busy_q;
    logic               fill_done_q;
    logic [STB_W-1:0]   stb_cnt_q;
    logic [35:0]        rdata_q;
    logic               rdata_vld_q;
    logic               par_err_q;
    logic [WAYS-1:0]    sel_l_q, sel_l_d;
    logic [WAYS-1:0]    wr_l_q, wr_l_d;
    logic               en_l_q, en_l_d;

    logic gnt;
    logic fill_accept;
    logic mem_xfer;
    logic fill_last;

    assign fill_last = op_fill_q && (fill_cnt_q == FILL_WORDS);

    // Next-state and arbitration. A fill parks in FILL_WAIT; the CPU only gets a
    // slot there when no memory word is offered, so grant and transfer never collide.
    always_comb begin
        state_d     = state_q;
        gnt         = 1'b0;
        fill_accept = 1'b0;
        mem_xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fill_req_h) begin
                    fill_accept = 1'b1;
                    state_d     = FILL_WAIT;
                end else if (bus.cpu_req_h) begin
                    gnt     = 1'b1;
                    state_d = bus.cpu_wr_h ? WR_SET : RD_ADR;
                end
            end
            RD_ADR:  state_d = RD_CAP;
            RD_CAP:  state_d = fill_busy_q ? FILL_WAIT : IDLE;
            WR_SET:  state_d = WR_STB;
            WR_STB:  if (stb_cnt_q == STB_LAST) state_d = WR_HLD;
            WR_HLD:  state_d = (fill_busy_q && !fill_last) ? FILL_WAIT : IDLE;
            FILL_WAIT: begin
                if (bus.mem_data_vld_h) begin
                    mem_xfer = 1'b1;
                    state_d  = WR_SET;
                end else if (bus.cpu_req_h) begin
                    gnt     = 1'b1;
                    state_d = bus.cpu_wr_h ? WR_SET : RD_ADR;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d     = IDLE;
            gnt         = 1'b0;
            fill_accept = 1'b0;
            mem_xfer    = 1'b0;
        end
    end

    // RAM control lines are decoded from the next state so they leave a flop cleanly.
    always_comb begin
        op_way_d = gnt ? bus.cpu_way : (mem_xfer ? fill_way_q : op_way_q);
        sel_l_d  = '1;
        wr_l_d   = '1;
        en_l_d   = 1'b1;
        case (state_d)
            RD_ADR, RD_CAP: begin
                sel_l_d[op_way_d] = 1'b0;
                en_l_d            = 1'b0;
            end
            WR_SET, WR_HLD: sel_l_d[op_way_d] = 1'b0;
            WR_STB: begin
                sel_l_d[op_way_d] = 1'b0;
                wr_l_d[op_way_d]  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_way_q    <= '0;
            op_adr_q    <= '0;
            op_wdata_q  <= '0;
            op_par_q    <= 1'b0;
            op_fill_q   <= 1'b0;
            fill_way_q  <= '0;
            fill_adr_q  <= '0;
            fill_cnt_q  <= '0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
            stb_cnt_q   <= '0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
            par_err_q   <= 1'b0;
            sel_l_q     <= '1;
            wr_l_q      <= '1;
            en_l_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_way_q    <= op_way_d;
            sel_l_q     <= sel_l_d;
            wr_l_q      <= wr_l_d;
            en_l_q      <= en_l_d;
            fill_done_q <= 1'b0;
            rdata_vld_q <= 1'b0;
            par_err_q   <= 1'b0;

            if (fill_accept) begin
                fill_way_q  <= bus.fill_way;
                fill_adr_q  <= bus.fill_adr;
                fill_cnt_q  <= '0;
                fill_busy_q <= 1'b1;
            end

            if (gnt) begin
                op_adr_q  <= bus.cpu_adr;
                op_fill_q <= 1'b0;
                if (bus.cpu_wr_h) begin
                    op_wdata_q <= bus.cpu_wdata;
                    op_par_q   <= ~^bus.cpu_wdata;
                end
            end

            // Critical word first: only the word offset wraps, the line index stays.
            if (mem_xfer) begin
                op_adr_q               <= fill_adr_q;
                op_wdata_q             <= bus.mem_data;
                op_par_q               <= ~^bus.mem_data;
                op_fill_q              <= 1'b1;
                fill_adr_q[OFS_W-1:0]  <= fill_adr_q[OFS_W-1:0] + OFS_W'(1);
                fill_cnt_q             <= fill_cnt_q + CNT_W'(1);
            end

            if (state_q == WR_SET) begin
                stb_cnt_q <= '0;
            end else if (state_q == WR_STB) begin
                stb_cnt_q <= stb_cnt_q + STB_W'(1);
            end

            if (state_q == RD_CAP) begin
                rdata_q     <= bus.cache_data_h;
                rdata_vld_q <= 1'b1;
                par_err_q   <= ~(^bus.cache_data_h ^ bus.csh_par_bit_h);
            end

            if ((state_q == WR_HLD) && fill_last) begin
                fill_busy_q <= 1'b0;
                fill_done_q <= 1'b1;
            end
        end
    end

    assign bus.cpu_gnt_h         = gnt;
    assign bus.cpu_rdata         = rdata_q;
    assign bus.cpu_rdata_vld_h   = rdata_vld_q;
    assign bus.par_err_h         = par_err_q;
    assign bus.mem_rdy_h         = (state_q == FILL_WAIT) && !reset;
    assign bus.fill_busy_h       = fill_busy_q;
    assign bus.fill_done_h       = fill_done_q;
    assign bus.cache_adr_h       = op_adr_q;
    assign bus.csh_sel_l         = sel_l_q;
    assign bus.csh_en_csh_data_l = en_l_q;
    assign bus.cache_wr_l        = wr_l_q;
    assign bus.mem_to_cache_h    = op_wdata_q;
    assign bus.csh_par_bit_in_h  = op_par_q;
endmodule

// File: tb/tb_csh_data_seq.sv
// Directed bench for csh_data_seq: a behavioural 4-way RAM sits on the cache side
// and each task drives one scenario and checks its own hand-computed results.
module tb_csh_data_seq;
    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    csh_data_seq_if #(.WAYS(4), .ADR_W(9)) bus ();

    csh_data_seq #(.WAYS(4), .WPL(4), .IDX_W(7), .WR_PULSE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural data RAM: writes on strobe, combinational read of the selected way.
    logic [35:0] ram_d [4][512];
    logic        ram_p [4][512];
    logic        flip_par = 1'b0;
    logic [1:0]  rd_way;

    always @(posedge clk) begin
        for (int w = 0; w < 4; w++) begin
            if (bus.cache_wr_l[w] === 1'b0) begin
                ram_d[w][bus.cache_adr_h] <= bus.mem_to_cache_h;
                ram_p[w][bus.cache_adr_h] <= bus.csh_par_bit_in_h;
            end
        end
    end

    always_comb begin
        rd_way = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (bus.csh_sel_l[w] == 1'b0) rd_way = 2'(w);
        end
    end

    assign bus.cache_data_h  = ram_d[rd_way][bus.cache_adr_h];
    assign bus.csh_par_bit_h = ram_p[rd_way][bus.cache_adr_h] ^ flip_par;

    // Event recorder sampled mid-cycle.
    int         wr_low_cyc;
    logic [3:0] last_wr_pat;
    logic [3:0] prev_wr = 4'hF;
    logic [8:0] wr_adr_q [$];
    int         done_cnt;
    int         rdy_in_cpu;
    bit         cpu_active;
    int         overlap = 0;
    int         multi_low = 0;

    always @(negedge clk) begin
        if (bus.cache_wr_l !== 4'hF) begin
            wr_low_cyc++;
            last_wr_pat = bus.cache_wr_l;
            if (prev_wr === 4'hF) wr_adr_q.push_back(bus.cache_adr_h);
            if ($countones(~bus.cache_wr_l) > 1) multi_low++;
        end
        prev_wr = bus.cache_wr_l;
        if (bus.fill_done_h === 1'b1) done_cnt++;
        if (bus.cpu_rdata_vld_h === 1'b1) cpu_active = 1'b0;
        if (cpu_active && bus.mem_rdy_h === 1'b1) rdy_in_cpu++;
        if (bus.cpu_gnt_h === 1'b1) begin
            cpu_active = 1'b1;
            if (bus.mem_rdy_h === 1'b1 && bus.mem_data_vld_h === 1'b1) overlap++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rec();
        wr_low_cyc  = 0;
        last_wr_pat = 4'hF;
        wr_adr_q.delete();
        done_cnt    = 0;
        rdy_in_cpu  = 0;
        cpu_active  = 1'b0;
    endtask

    task automatic cpu_do(input logic wr, input logic [1:0] way, input logic [8:0] adr,
                          input logic [35:0] data, output bit ok, output int gcyc);
        ok   = 1'b0;
        gcyc = -1;
        bus.cpu_req_h = 1'b1;
        bus.cpu_wr_h  = wr;
        bus.cpu_way   = way;
        bus.cpu_adr   = adr;
        bus.cpu_wdata = data;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.cpu_gnt_h === 1'b1) begin
                ok   = 1'b1;
                gcyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        bus.cpu_req_h = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] way, input logic [8:0] adr, output bit ok,
                            output int lat, output logic [35:0] rd, output logic err);
        int g;
        bit got;
        cpu_do(1'b0, way, adr, 36'h0, got, g);
        ok  = 1'b0;
        lat = -1;
        rd  = 'x;
        err = 1'bx;
        if (got) begin
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                if (bus.cpu_rdata_vld_h === 1'b1) begin
                    ok  = 1'b1;
                    lat = cyc - g;
                    rd  = bus.cpu_rdata;
                    err = bus.par_err_h;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic fill_start(input logic [1:0] way, input logic [8:0] adr,
                              output bit ok, output int bcyc);
        ok   = 1'b0;
        bcyc = -1;
        bus.fill_req_h = 1'b1;
        bus.fill_way   = way;
        bus.fill_adr   = adr;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.fill_busy_h === 1'b1) begin
                ok   = 1'b1;
                bcyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        bus.fill_req_h = 1'b0;
    endtask

    task automatic mem_send(input logic [35:0] d, output bit ok);
        ok = 1'b0;
        bus.mem_data_vld_h = 1'b1;
        bus.mem_data       = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.mem_rdy_h === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.mem_data_vld_h = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick(1);
            if (done_cnt > 0) ok = 1'b1;
        end
        tick(3);
    endtask

    localparam logic [35:0] D1 = 36'o123456701234;
    localparam logic [35:0] D2 = 36'h5_A5A5_A5A5;

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        @(negedge clk);
        compared++;
        if ({bus.cache_wr_l, bus.csh_sel_l, bus.csh_en_csh_data_l} !== 9'h1FF) begin
            mismatched++;
            $display("[TB] FAIL reset_lo: got %b%b%b want 111111111", bus.cache_wr_l, bus.csh_sel_l, bus.csh_en_csh_data_l);
        end
        compared++;
        if ({bus.cpu_gnt_h, bus.cpu_rdata_vld_h, bus.par_err_h, bus.fill_busy_h, bus.fill_done_h,
             bus.mem_rdy_h, bus.csh_par_bit_in_h} !== 7'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_hi: got %b%b%b%b%b%b%b want 0000000", bus.cpu_gnt_h, bus.cpu_rdata_vld_h,
                     bus.par_err_h, bus.fill_busy_h, bus.fill_done_h, bus.mem_rdy_h, bus.csh_par_bit_in_h);
        end
        compared++;
        if ({bus.cache_adr_h, bus.mem_to_cache_h, bus.cpu_rdata} !== 81'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got adr %h wd %h rd %h want 0", bus.cache_adr_h, bus.mem_to_cache_h, bus.cpu_rdata);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_cpu_write();
        bit ok;
        int g;
        clear_rec();
        cpu_do(1'b1, 2'd1, 9'h005, D1, ok, g);
        tick(8);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL wr_gnt: got %0d want 1", ok);
        end
        compared++;
        if (wr_low_cyc !== 2) begin
            mismatched++;
            $display("[TB] FAIL wr_pulse_len: got %0d want 2", wr_low_cyc);
        end
        compared++;
        if (last_wr_pat !== 4'b1101) begin
            mismatched++;
            $display("[TB] FAIL wr_strobe: got %b want 1101", last_wr_pat);
        end
        compared++;
        if (ram_d[1][9'h005] !== D1) begin
            mismatched++;
            $display("[TB] FAIL wr_data: got %o want %o", ram_d[1][9'h005], D1);
        end
        compared++;
        if (ram_p[1][9'h005] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wr_parity: got %b want 0", ram_p[1][9'h005]);
        end
    endtask

    task automatic test_cpu_read();
        bit          ok;
        int          lat;
        logic [35:0] rd;
        logic        err;
        cpu_read(2'd1, 9'h005, ok, lat, rd, err);
        compared++;
        if (ok !== 1'b1 || lat !== 3) begin
            mismatched++;
            $display("[TB] FAIL rd_latency: got ok %0d lat %0d want ok 1 lat 3", ok, lat);
        end
        compared++;
        if (rd !== D1 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rd_good: got %o err %b want %o err 0", rd, err, D1);
        end
        tick(2);
        flip_par = 1'b1;
        cpu_read(2'd1, 9'h005, ok, lat, rd, err);
        flip_par = 1'b0;
        compared++;
        if (ok !== 1'b1 || err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rd_par_err: got ok %0d err %b want ok 1 err 1", ok, err);
        end
        compared++;
        if (rd !== D1) begin
            mismatched++;
            $display("[TB] FAIL rd_par_data: got %o want %o", rd, D1);
        end
        tick(2);
    endtask

    task automatic test_fill_back_to_back();
        logic [35:0] fw [4]      = '{36'hF_0000_0001, 36'hF_0000_0002, 36'hF_0000_0003, 36'hF_0000_0004};
        logic [8:0]  exp_adr [4] = '{9'h00E, 9'h00F, 9'h00C, 9'h00D};
        bit ok;
        int b;
        clear_rec();
        fill_start(2'd3, 9'h00E, ok, b);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fill_busy_rise: got %0d want 1", ok);
        end
        for (int k = 0; k < 4; k++) mem_send(fw[k], ok);
        wait_done(ok);
        compared++;
        if (wr_adr_q.size() !== 4) begin
            mismatched++;
            $display("[TB] FAIL fill_wr_count: got %0d want 4", wr_adr_q.size());
        end
        for (int k = 0; k < 4 && k < wr_adr_q.size(); k++) begin
            compared++;
            if (wr_adr_q[k] !== exp_adr[k]) begin
                mismatched++;
                $display("[TB] FAIL fill_order[%0d]: got %h want %h", k, wr_adr_q[k], exp_adr[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (ram_d[3][exp_adr[k]] !== fw[k]) begin
                mismatched++;
                $display("[TB] FAIL fill_data[%0d]: got %h want %h", k, ram_d[3][exp_adr[k]], fw[k]);
            end
        end
        compared++;
        if (done_cnt !== 1 || bus.fill_busy_h !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fill_done: got done %0d busy %b want done 1 busy 0", done_cnt, bus.fill_busy_h);
        end
    endtask

    task automatic test_fill_gap_cpu_read();
        logic [35:0] gw [4]      = '{36'h1_1111_1111, 36'h2_2222_2222, 36'h3_3333_3333, 36'h4_4444_4444};
        logic [8:0]  exp_adr [4] = '{9'h021, 9'h022, 9'h023, 9'h020};
        bit          ok;
        int          b;
        int          start;
        int          lat;
        logic [35:0] rd;
        logic        err;
        clear_rec();
        fill_start(2'd2, 9'h021, ok, b);
        mem_send(gw[0], ok);
        start = cyc;
        cpu_read(2'd1, 9'h005, ok, lat, rd, err);
        while (cyc - start < 10) tick(1);
        compared++;
        if (ok !== 1'b1 || lat !== 3 || rd !== D1) begin
            mismatched++;
            $display("[TB] FAIL gap_read: got ok %0d lat %0d rd %o want ok 1 lat 3 rd %o", ok, lat, rd, D1);
        end
        compared++;
        if (rdy_in_cpu !== 0) begin
            mismatched++;
            $display("[TB] FAIL gap_rdy_low: got %0d rdy cycles want 0", rdy_in_cpu);
        end
        for (int k = 1; k < 4; k++) mem_send(gw[k], ok);
        wait_done(ok);
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (ram_d[2][exp_adr[k]] !== gw[k]) begin
                mismatched++;
                $display("[TB] FAIL gap_data[%0d]: got %h want %h", k, ram_d[2][exp_adr[k]], gw[k]);
            end
        end
        compared++;
        if (done_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL gap_done: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_arbitration();
        bit          fok;
        bit          cok;
        bit          ok;
        int          bcyc;
        int          gcyc;
        int          req_cyc;
        logic [35:0] rd = 'x;
        clear_rec();
        req_cyc = cyc;
        fork
            fill_start(2'd0, 9'h040, fok, bcyc);
            cpu_do(1'b0, 2'd1, 9'h005, 36'h0, cok, gcyc);
        join
        for (int i = 0; i < 10 && bus.cpu_rdata_vld_h !== 1'b1; i++) @(negedge clk);
        if (bus.cpu_rdata_vld_h === 1'b1) rd = bus.cpu_rdata;
        tick(1);
        compared++;
        if (fok !== 1'b1 || bcyc - req_cyc !== 1) begin
            mismatched++;
            $display("[TB] FAIL arb_fill_first: got ok %0d busy at +%0d want ok 1 at +1", fok, bcyc - req_cyc);
        end
        compared++;
        if (cok !== 1'b1 || gcyc - req_cyc !== 1) begin
            mismatched++;
            $display("[TB] FAIL arb_cpu_in_gap: got ok %0d gnt at +%0d want ok 1 at +1", cok, gcyc - req_cyc);
        end
        compared++;
        if (rd !== D1 || rdy_in_cpu !== 0) begin
            mismatched++;
            $display("[TB] FAIL arb_read: got %o rdy %0d want %o rdy 0", rd, rdy_in_cpu, D1);
        end
        for (int k = 0; k < 4; k++) mem_send(36'hC_0000_0000 | 36'(k), ok);
        wait_done(ok);
        compared++;
        if (ram_d[0][9'h043] !== 36'hC_0000_0003 || done_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL arb_fill_end: got %h done %0d want c00000003 done 1", ram_d[0][9'h043], done_cnt);
        end
    endtask

    task automatic test_reset_in_wr_stb();
        bit          ok;
        int          b;
        int          g;
        int          lat;
        logic [35:0] rd;
        logic        err;
        clear_rec();
        fill_start(2'd0, 9'h052, ok, b);
        for (int k = 0; k < 4; k++) mem_send(36'h7_0000_0000 | 36'(k), ok);
        tick(1);
        @(negedge clk);
        compared++;
        if (bus.cache_wr_l !== 4'b1110) begin
            mismatched++;
            $display("[TB] FAIL rst_stb_active: got %b want 1110", bus.cache_wr_l);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if ({bus.cache_wr_l, bus.csh_sel_l, bus.fill_busy_h} !== 9'b111111110) begin
            mismatched++;
            $display("[TB] FAIL rst_stb_abort: got wr %b sel %b busy %b want 1111 1111 0",
                     bus.cache_wr_l, bus.csh_sel_l, bus.fill_busy_h);
        end
        tick(6);
        compared++;
        if (done_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL rst_no_done: got %0d want 0", done_cnt);
        end
        cpu_do(1'b1, 2'd2, 9'h033, D2, ok, g);
        tick(6);
        cpu_read(2'd2, 9'h033, ok, lat, rd, err);
        compared++;
        if (ok !== 1'b1 || lat !== 3 || rd !== D2 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_recover: got ok %0d lat %0d rd %h err %b want 1 3 %h 0", ok, lat, rd, err, D2);
        end
    endtask

    task automatic test_invariants();
        compared++;
        if (overlap !== 0) begin
            mismatched++;
            $display("[TB] FAIL gnt_xfer_overlap: got %0d want 0", overlap);
        end
        compared++;
        if (multi_low !== 0) begin
            mismatched++;
            $display("[TB] FAIL one_strobe: got %0d want 0", multi_low);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.cpu_req_h      = 1'b0;
        bus.cpu_wr_h       = 1'b0;
        bus.cpu_way        = 2'd0;
        bus.cpu_adr        = 9'h0;
        bus.cpu_wdata      = 36'h0;
        bus.fill_req_h     = 1'b0;
        bus.fill_way       = 2'd0;
        bus.fill_adr       = 9'h0;
        bus.mem_data_vld_h = 1'b0;
        bus.mem_data       = 36'h0;
        #1;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_fill_back_to_back();
        test_fill_gap_cpu_read();
        test_arbitration();
        test_reset_in_wr_stb();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
